// File: rtl/lif_param_serializer.sv
// lif_param_serializer: MSB-first serial loader for a LIF neuron's config port.
// Shifts one frame under load_mode, then waits (bounded) for params_ready.
module lif_param_serializer #(
   parameter int PARAM_BITS    = 24,
   parameter int BIT_DIV       = 1,
   parameter int READY_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [PARAM_BITS-1:0] param_word,
   input  logic                  params_ready,
   output logic                  load_mode,
   output logic                  serial_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BC_W = $clog2(PARAM_BITS);
   localparam int DC_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int WC_W = $clog2(READY_TIMEOUT + 1);

   localparam logic [BC_W-1:0] BC_LAST = BC_W'(PARAM_BITS - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(BIT_DIV - 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(READY_TIMEOUT);
   localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [PARAM_BITS-1:0] sreg_q, sreg_d;
   logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DC_W-1:0]       div_cnt_q, div_cnt_d;
   logic [WC_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic                  load_mode_q, load_mode_d;
   logic                  serial_q, serial_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      load_mode_d = load_mode_q;
      serial_d    = serial_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_SHIFT;
               sreg_d      = param_word;
               bit_cnt_d   = '0;
               div_cnt_d   = '0;
               load_mode_d = 1'b1;
               serial_d    = param_word[PARAM_BITS-1];
               busy_d      = 1'b1;
               err_d       = 1'b0;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d     = S_IDLE;
               load_mode_d = 1'b0;
               serial_d    = 1'b0;
               busy_d      = 1'b0;
            end else if (div_cnt_q == DC_LAST) begin
               div_cnt_d = '0;
               if (bit_cnt_q == BC_LAST) begin
                  state_d     = S_WAIT;
                  load_mode_d = 1'b0;
                  serial_d    = 1'b0;
                  wait_cnt_d  = WC_ONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  sreg_d    = sreg_q << 1;
                  serial_d  = sreg_q[PARAM_BITS-2];
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            // First WAIT cycle masks params_ready; a late ack beats timeout.
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (wait_cnt_q != WC_ONE && params_ready) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (wait_cnt_q == WC_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            load_mode_d = 1'b0;
            serial_d    = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         load_mode_q <= 1'b0;
         serial_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         load_mode_q <= load_mode_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign load_mode   = load_mode_q;
   assign serial_data = serial_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_lif_param_serializer.sv
// Bench for lif_param_serializer: table vectors, random frames and reset
// corner cases against a per-cycle trace predicted from the frame rules.
module tb_lif_param_serializer;

   localparam int PB = 24;
   localparam int TO = 15;

   logic          clk;
   logic          rst_n;
   logic          start, abort, ready;
   logic [PB-1:0] word;
   bit            sel3;

   logic lm_a, sd_a, busy_a, done_a, err_a;
   logic lm_b, sd_b, busy_b, done_b, err_b;
   logic lm, sd, bsy, dn, er;

   lif_param_serializer #(.PARAM_BITS(PB), .BIT_DIV(1), .READY_TIMEOUT(TO)) u_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start & ~sel3),
      .abort        (abort & ~sel3),
      .param_word   (word),
      .params_ready (ready & ~sel3),
      .load_mode    (lm_a),
      .serial_data  (sd_a),
      .busy         (busy_a),
      .done         (done_a),
      .err          (err_a)
   );

   lif_param_serializer #(.PARAM_BITS(PB), .BIT_DIV(3), .READY_TIMEOUT(TO)) u_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start & sel3),
      .abort        (abort & sel3),
      .param_word   (word),
      .params_ready (ready & sel3),
      .load_mode    (lm_b),
      .serial_data  (sd_b),
      .busy         (busy_b),
      .done         (done_b),
      .err          (err_b)
   );

   assign lm  = sel3 ? lm_b   : lm_a;
   assign sd  = sel3 ? sd_b   : sd_a;
   assign bsy = sel3 ? busy_b : busy_a;
   assign dn  = sel3 ? done_b : done_a;
   assign er  = sel3 ? err_b  : err_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   logic [4:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] ob(bit l, bit s, bit b, bit d, bit e);
      return {l, s, b, d, e};
   endfunction

   // Expected {load_mode,serial,busy,done,err} per cycle after the start edge.
   task automatic build(input logic [PB-1:0] w, input int bd, input int rf, input int ab);
      int n;
      int idx;
      bit rdy;
      exp_q.delete();
      n = PB * bd;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(ob(1, w[PB-1-i/bd], 1, 0, 0));
         if (ab == i) begin
            exp_q.push_back(ob(0, 0, 0, 0, 0));
            exp_q.push_back(ob(0, 0, 0, 0, 0));
            return;
         end
      end
      for (int wc = 1; wc <= TO; wc++) begin
         idx = n + wc - 1;
         exp_q.push_back(ob(0, 0, 1, 0, 0));
         if (ab == idx) begin
            exp_q.push_back(ob(0, 0, 0, 0, 0));
            exp_q.push_back(ob(0, 0, 0, 0, 0));
            return;
         end
         rdy = (rf == 0) || (wc >= rf);
         if (wc >= 2 && rdy) begin
            exp_q.push_back(ob(0, 0, 0, 1, 0));
            exp_q.push_back(ob(0, 0, 0, 0, 0));
            return;
         end
         if (wc == TO) begin
            exp_q.push_back(ob(0, 0, 0, 0, 1));
            exp_q.push_back(ob(0, 0, 0, 0, 1));
            return;
         end
      end
   endtask

   // Called at a negedge; drives start now and checks every following cycle.
   task automatic run_frame(input bit s3, input logic [PB-1:0] w, input int rf,
                            input int ab, input int bs, input bit sa,
                            output int ndone, output int nlm, output logic last_err);
      int bd;
      int n;
      bd = s3 ? 3 : 1;
      n  = PB * bd;
      build(w, bd, rf, ab);
      sel3  = s3;
      word  = w;
      start = 1'b1;
      abort = sa;
      ready = (rf == 0);
      ndone = 0;
      nlm   = 0;
      last_err = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("trace w=%h cyc%0d", w, i), {27'd0, lm, sd, bsy, dn, er},
             {27'd0, exp_q[i]});
         nlm += int'(lm);
         ndone += int'(dn);
         last_err = er;
         start = (i == bs);
         if (i == bs) word = ~w;
         abort = (i == ab);
         ready = (rf == 0) || (i >= n + rf - 1);
      end
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b0;
   endtask

   typedef struct {
      bit            s3;
      logic [PB-1:0] w;
      int            rf;
      int            ab;
      int            bs;
      bit            sa;
      int            e_done;
      int            e_lm;
      logic          e_err;
   } vec_t;

   vec_t tv[12];

   initial begin
      int   nd, nl;
      logic le;
      int   bd, n, rf, ab, bs;
      bit   s3, sa;

      tv[0]  = '{0, 24'hA5C30F,  3, -1, -1, 0, 1, 24, 0};
      tv[1]  = '{1, 24'h800001,  2, -1, -1, 0, 1, 72, 0};
      tv[2]  = '{0, 24'h5A5A5A, 99, -1, -1, 0, 0, 24, 1};
      tv[3]  = '{0, 24'h3C3C3C,  0, -1, -1, 0, 1, 24, 0};
      tv[4]  = '{0, 24'hFFFFFF,  4, 10, -1, 0, 0, 11, 0};
      tv[5]  = '{0, 24'h123456,  4, -1,  5, 0, 1, 24, 0};
      tv[6]  = '{0, 24'hC00003, 15, -1, -1, 0, 1, 24, 0};
      tv[7]  = '{0, 24'h000001, 16, -1, -1, 0, 0, 24, 1};
      tv[8]  = '{0, 24'h0F0F0F, 99, 38, -1, 0, 0, 24, 0};
      tv[9]  = '{0, 24'hABCDEF,  2, 25, -1, 1, 0, 24, 0};
      tv[10] = '{1, 24'h00F0F1,  5, 33, -1, 0, 0, 34, 0};
      tv[11] = '{1, 24'h800001, 99, -1, -1, 0, 0, 72, 1};

      sel3  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b0;
      word  = '0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("rst load_mode", {31'd0, lm_a}, 32'd0);
      chk("rst serial", {31'd0, sd_a}, 32'd0);
      chk("rst busy", {31'd0, busy_a}, 32'd0);
      chk("rst done", {31'd0, done_a}, 32'd0);
      chk("rst err", {31'd0, err_a}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 12; v++) begin
         run_frame(tv[v].s3, tv[v].w, tv[v].rf, tv[v].ab, tv[v].bs, tv[v].sa, nd, nl, le);
         chk($sformatf("vec%0d done pulses", v), nd, tv[v].e_done);
         chk($sformatf("vec%0d load_mode cycles", v), nl, tv[v].e_lm);
         chk($sformatf("vec%0d err", v), {31'd0, le}, {31'd0, tv[v].e_err});
      end

      // Async reset in the middle of a frame, then restart on first edge.
      sel3  = 1'b0;
      word  = 24'h9E3779;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst load_mode", {31'd0, lm_a}, 32'd0);
      chk("midrst serial", {31'd0, sd_a}, 32'd0);
      chk("midrst busy", {31'd0, busy_a}, 32'd0);
      chk("midrst done", {31'd0, done_a}, 32'd0);
      chk("midrst err", {31'd0, err_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(0, 24'h2468AC, 3, -1, -1, 0, nd, nl, le);
      chk("postrst done", nd, 1);
      chk("postrst lm cycles", nl, 24);

      // Reset in IDLE after a timeout clears the sticky err.
      run_frame(0, 24'h777777, 99, -1, -1, 0, nd, nl, le);
      chk("timeout err set", {31'd0, le}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("idle rst clears err", {31'd0, err_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 40; r++) begin
         s3 = bit'($urandom % 2);
         bd = s3 ? 3 : 1;
         n  = PB * bd;
         rf = int'($urandom_range(0, 18));
         ab = ($urandom % 3 == 0) ? int'($urandom_range(0, n + 16)) : -1;
         bs = (ab < 0 && $urandom % 2 == 1) ? int'($urandom_range(0, n - 1)) : -1;
         sa = ($urandom % 4 == 0);
         run_frame(s3, PB'($urandom), rf, ab, bs, sa, nd, nl, le);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
